anim_sequencer: RTL and testbench

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

---
 rtl/goose_pkg.sv | 35 +++
 rtl/btn_edge_sync.sv | 37 +++
 rtl/anim_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_anim_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/goose_pkg.sv
// goose_pkg: shared types and constants for the animation sequencer.
//   state_e      : sequencer FSM state encoding (PLAY=0, PAUSE=1, STEP_WAIT=2)
//   FRAME_W      : animation frame index width
//   period_m1()  : speed select -> (advance period - 1) in video frames
package goose_pkg;

   localparam int FRAME_W = 2;
   localparam int SUB_W   = 5;
   localparam int HOLD_W  = 8;
   localparam int FC_W    = 7;

   typedef enum logic [1:0] {
      ST_PLAY      = 2'd0,
      ST_PAUSE     = 2'd1,
      ST_STEP_WAIT = 2'd2
   } state_e;

   // Advance period minus one, indexed by speed: 00=8, 01=4, 10=16, 11=32
   localparam logic [SUB_W-1:0] PERIOD_M1_SPD0 = 5'd7;
   localparam logic [SUB_W-1:0] PERIOD_M1_SPD1 = 5'd3;
   localparam logic [SUB_W-1:0] PERIOD_M1_SPD2 = 5'd15;
   localparam logic [SUB_W-1:0] PERIOD_M1_SPD3 = 5'd31;

   function automatic logic [SUB_W-1:0] period_m1(input logic [1:0] spd);
      logic [SUB_W-1:0] p;
      case (spd)
         2'b00:   p = PERIOD_M1_SPD0;
         2'b01:   p = PERIOD_M1_SPD1;
         2'b10:   p = PERIOD_M1_SPD2;
         default: p = PERIOD_M1_SPD3;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: two-flop synchronizer for an asynchronous level input
// followed by a rising-edge detector.
//   clk, rst_n : clock, async active-low reset
//   btn_in     : asynchronous button level
//   edge_o     : one-cycle pulse on each synchronized rising edge
module btn_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic edge_o
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/anim_sequencer.sv
// anim_sequencer: sprite animation frame / background scene sequencer.
//   clk, rst_n    : pixel clock, async active-low reset
//   frame_start   : one-cycle pulse at pixel (0,0) of each video frame
//   play_btn      : async play/pause toggle (level)
//   step_btn      : async single-step (level)
//   speed         : advance period select (00=8, 01=4, 10=16, 11=32 frames)
//   bg_auto       : 1 = background cycles on its own, 0 = bg_sel_in
//   bg_sel_in     : manual background select
//   frame_num     : current animation frame index
//   bg_sel        : current background scene
//   frame_counter : free-running 7-bit video frame count
//   beat          : one-cycle pulse when frame_num takes a new value
//   state         : FSM state (PLAY=0, PAUSE=1, STEP_WAIT=2)
// Build option: define ANIM_PINGPONG_EN for ping-pong frame order
// (0,1,..,N-1,..,1,0,1,..); otherwise frames loop 0..N-1.
//
// state     | meaning
// ----------+---------------------------------------------------------
// PLAY      | frames advance every speed-selected period
// PAUSE     | frame held; step edge arms a single advance
// STEP_WAIT | advance one frame at next frame_start, then back to PAUSE
module anim_sequencer
   import goose_pkg::*;
#(
   parameter int NUM_FRAMES = 4,
   parameter int BG_HOLD    = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               play_btn,
   input  logic               step_btn,
   input  logic [1:0]         speed,
   input  logic               bg_auto,
   input  logic [1:0]         bg_sel_in,
   output logic [FRAME_W-1:0] frame_num,
   output logic [1:0]         bg_sel,
   output logic [FC_W-1:0]    frame_counter,
   output logic               beat,
   output logic [1:0]         state
);

   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(BG_HOLD - 1);

   logic play_edge, step_edge;

   btn_edge_sync u_play_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (play_btn),
      .edge_o (play_edge)
   );

   btn_edge_sync u_step_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (step_btn),
      .edge_o (step_edge)
   );

   state_e              state_q, state_d;
   logic [FRAME_W-1:0]  frame_num_q, frame_num_d;
   logic [1:0]          bg_sel_q, bg_sel_d;
   logic [FC_W-1:0]     frame_counter_q, frame_counter_d;
   logic                beat_q, beat_d;
   logic [SUB_W-1:0]    sub_q, sub_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                advance;
`ifdef ANIM_PINGPONG_EN
   logic                dir_q, dir_d;   // 0 = forward, 1 = backward
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_PLAY;
      else        state_q <= state_d;
   end

   // next state; play edge always outranks step edge and frame_start
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PLAY: begin
            if (play_edge) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (play_edge)      state_d = ST_PLAY;
            else if (step_edge) state_d = ST_STEP_WAIT;
         end
         ST_STEP_WAIT: begin
            if (play_edge)        state_d = ST_PLAY;
            else if (frame_start) state_d = ST_PAUSE;
         end
         default: state_d = ST_PLAY;
      endcase
   end

   // outputs and datapath; every visible update is keyed to frame_start
   always_comb begin
      advance         = 1'b0;
      sub_d           = sub_q;
      frame_num_d     = frame_num_q;
      bg_sel_d        = bg_sel_q;
      hold_d          = hold_q;
      frame_counter_d = frame_counter_q;
`ifdef ANIM_PINGPONG_EN
      dir_d           = dir_q;
`endif

      if (state_q == ST_PLAY) begin
         if (frame_start) begin
            // >= rather than == so a speed cut below the current count
            // advances at once instead of wrapping the sub-counter
            if (sub_q >= period_m1(speed)) begin
               advance = 1'b1;
               sub_d   = '0;
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end
      end else begin
         if (state_q == ST_STEP_WAIT && frame_start && !play_edge) advance = 1'b1;
         // resuming play always starts a fresh period
         if (play_edge) sub_d = '0;
      end

`ifdef ANIM_PINGPONG_EN
      if (advance) begin
         if (!dir_q) begin
            if (frame_num_q == LAST_FRAME) begin
               frame_num_d = frame_num_q - 1'b1;
               dir_d       = 1'b1;
            end else begin
               frame_num_d = frame_num_q + 1'b1;
            end
         end else begin
            if (frame_num_q == '0) begin
               frame_num_d = frame_num_q + 1'b1;
               dir_d       = 1'b0;
            end else begin
               frame_num_d = frame_num_q - 1'b1;
            end
         end
      end
`else
      if (advance) frame_num_d = (frame_num_q == LAST_FRAME) ? '0 : frame_num_q + 1'b1;
`endif

      if (frame_start) begin
         frame_counter_d = frame_counter_q + 1'b1;
         if (bg_auto) begin
            if (hold_q >= HOLD_LAST) begin
               hold_d   = '0;
               bg_sel_d = bg_sel_q + 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end else begin
            bg_sel_d = bg_sel_in;
         end
      end
      if (!bg_auto) hold_d = '0;

      beat_d = advance;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_num_q     <= '0;
         bg_sel_q        <= '0;
         frame_counter_q <= '0;
         beat_q          <= 1'b0;
         sub_q           <= '0;
         hold_q          <= '0;
`ifdef ANIM_PINGPONG_EN
         dir_q           <= 1'b0;
`endif
      end else begin
         frame_num_q     <= frame_num_d;
         bg_sel_q        <= bg_sel_d;
         frame_counter_q <= frame_counter_d;
         beat_q          <= beat_d;
         sub_q           <= sub_d;
         hold_q          <= hold_d;
`ifdef ANIM_PINGPONG_EN
         dir_q           <= dir_d;
`endif
      end
   end

   assign frame_num     = frame_num_q;
   assign bg_sel        = bg_sel_q;
   assign frame_counter = frame_counter_q;
   assign beat          = beat_q;
   assign state         = state_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: self-checking bench for anim_sequencer.
// Honors ANIM_PINGPONG_EN the same way the design does.
module tb_anim_sequencer;

   localparam int NF = 4;
   localparam int BH = 4;
   localparam int M_PLAY = 0, M_PAUSE = 1, M_STEP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       play_btn = 1'b0;
   logic       step_btn = 1'b0;
   logic [1:0] speed = 2'b00;
   logic       bg_auto = 1'b0;
   logic [1:0] bg_sel_in = 2'b00;
   logic [1:0] frame_num;
   logic [1:0] bg_sel;
   logic [6:0] frame_counter;
   logic       beat;
   logic [1:0] state;

   anim_sequencer #(.NUM_FRAMES(NF), .BG_HOLD(BH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .play_btn      (play_btn),
      .step_btn      (step_btn),
      .speed         (speed),
      .bg_auto       (bg_auto),
      .bg_sel_in     (bg_sel_in),
      .frame_num     (frame_num),
      .bg_sel        (bg_sel),
      .frame_counter (frame_counter),
      .beat          (beat),
      .state         (state)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // reference model: abstract per-event state
   int m_state, m_frame, m_bg, m_fc, m_sub, m_hold, m_pos;
   bit m_adv;
   int n_beat_dut;
   bit capture;
   int obs_seq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int period(input logic [1:0] spd);
      case (spd)
         2'd0:    return 8;
         2'd1:    return 4;
         2'd2:    return 16;
         default: return 32;
      endcase
   endfunction

   task automatic model_reset();
      m_state = M_PLAY; m_frame = 0; m_bg = 0; m_fc = 0;
      m_sub = 0; m_hold = 0; m_pos = 0; m_adv = 0;
   endtask

   task automatic model_advance();
      m_adv = 1;
`ifdef ANIM_PINGPONG_EN
      // position along a bounce path of length 2N-2, folded back to a frame index
      m_pos   = (m_pos + 1) % (2*NF - 2);
      m_frame = (m_pos < NF) ? m_pos : (2*NF - 2 - m_pos);
`else
      m_frame = (m_frame + 1) % NF;
`endif
   endtask

   task automatic model_frame();
      m_adv = 0;
      m_fc  = (m_fc + 1) % 128;
      if (m_state == M_PLAY) begin
         if (m_sub >= period(speed) - 1) begin
            model_advance();
            m_sub = 0;
         end else m_sub++;
      end else if (m_state == M_STEP) begin
         model_advance();
         m_state = M_PAUSE;
      end
      if (bg_auto) begin
         if (m_hold == BH - 1) begin
            m_hold = 0;
            m_bg   = (m_bg + 1) % 4;
         end else m_hold++;
      end else begin
         m_hold = 0;
         m_bg   = bg_sel_in;
      end
   endtask

   task automatic model_play();
      if (m_state == M_PLAY) m_state = M_PAUSE;
      else begin
         m_state = M_PLAY;
         m_sub   = 0;
      end
   endtask

   task automatic model_step();
      if (m_state == M_PAUSE) m_state = M_STEP;
   endtask

   task automatic tick();
      @(negedge clk) frame_start = 1'b1;
      model_frame();
      @(negedge clk) frame_start = 1'b0;
      check("frame_num", frame_num, m_frame);
      check("bg_sel", bg_sel, m_bg);
      check("frame_counter", frame_counter, m_fc);
      check("state", state, m_state);
      check("beat", beat, m_adv);
      if (beat === 1'b1) n_beat_dut++;
      if (capture && beat === 1'b1) obs_seq.push_back(int'(frame_num));
      @(negedge clk);
      check("beat_clear", beat, 0);
      check("frame_hold", frame_num, m_frame);
   endtask

   task automatic press(input bit p, input bit s);
      @(negedge clk);
      play_btn = p;
      step_btn = s;
      repeat (4) @(negedge clk);
      play_btn = 1'b0;
      step_btn = 1'b0;
      repeat (3) @(negedge clk);
      if (p) model_play();
      else if (s) model_step();
      check("state_after_btn", state, m_state);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_frame_num"}, frame_num, 0);
      check({tag, "_bg_sel"}, bg_sel, 0);
      check({tag, "_frame_counter"}, frame_counter, 0);
      check({tag, "_beat"}, beat, 0);
      check({tag, "_state"}, state, 0);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk) rst_n = 1'b0;
      #1 check_reset_outputs(tag);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      int exp_seq[8];
      int guard;
      model_reset();
      n_beat_dut = 0;
      capture    = 0;

      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // free run at speed 00: four advances in 32 frames
      for (int i = 0; i < 32; i++) tick();
      check("beats_in_32", n_beat_dut, 4);
      check("wrap_to_0", frame_num, 0);

      // pause at frame 2, hold for 40 frames, then single step
      guard = 0;
      while (m_frame != 2 && guard < 64) begin
         tick();
         guard++;
      end
      check("reach_frame2", frame_num, 2);
      press(1'b0, 1'b1);              // step ignored in PLAY
      check("step_ignored_play", state, M_PLAY);
      press(1'b1, 1'b0);
      check("paused", state, M_PAUSE);
      for (int i = 0; i < 40; i++) tick();
      check("pause_hold", frame_num, 2);
      press(1'b0, 1'b1);
      check("step_wait", state, M_STEP);
      tick();
      check("stepped_frame", frame_num, 3);
      check("back_to_pause", state, M_PAUSE);

      // both buttons together in PAUSE: play wins
      press(1'b1, 1'b1);
      check("play_wins", state, M_PLAY);

      // speed overshoot: sub-counter at 10 with period 16, then period 4
      speed = 2'b10;
      for (int i = 0; i < 10; i++) tick();
      speed = 2'b01;
      tick();
      check("overshoot_beat", m_adv, 1);
      check("overshoot_dut", frame_num, 0);

      // background auto cycling with hold 4, then manual override
      bg_auto = 1'b0; bg_sel_in = 2'd0;
      tick();
      check("bg_manual0", bg_sel, 0);
      bg_auto = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      check("bg_auto_wrap", bg_sel, 0);
      bg_auto = 1'b0; bg_sel_in = 2'd2;
      tick();
      check("bg_manual2", bg_sel, 2);

      // play edge in STEP_WAIT returns to PLAY without stepping
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      check("armed", state, M_STEP);
      press(1'b1, 1'b0);
      check("play_from_step", state, M_PLAY);

      // randomized mix of frames, buttons and configuration changes
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5) tick();
         else if (r == 6) press(1'b1, 1'b0);
         else if (r == 7) press(1'b0, 1'b1);
         else if (r == 8) speed = 2'($urandom_range(0, 3));
         else begin
            bg_auto   = 1'($urandom_range(0, 1));
            bg_sel_in = 2'($urandom_range(0, 3));
         end
      end

      // long run at period 32: frame order after reset
      bg_auto = 1'b0;
      pulse_reset("rst_seq");
      speed   = 2'b11;
      capture = 1;
      obs_seq = {};
      obs_seq.push_back(int'(frame_num));
      for (int i = 0; i < 256; i++) tick();
      capture = 0;
`ifdef ANIM_PINGPONG_EN
      exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
      exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      check("seq_len", obs_seq.size() >= 8 ? 1 : 0, 1);
      for (int i = 0; i < 8; i++)
         check($sformatf("seq[%0d]", i), (i < obs_seq.size()) ? obs_seq[i] : -1, exp_seq[i]);

      // reset during STEP_WAIT discards the pending step
      speed = 2'b00;
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      check("pre_rst_step", state, M_STEP);
      pulse_reset("rst_step");
      repeat (2) @(negedge clk);
      tick();
      check("no_step_after_rst", frame_num, 0);
      check("play_after_rst", state, M_PLAY);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
